// File: rtl/video_timing_gen.sv
// video_timing_gen: video timing with three presets plus a custom mode, switched only at frame boundaries.
// Defining VIDEO_TIMING_GEN_TPG_EN adds an 8-bar colour test pattern on O_data_r/g/b.
module video_timing_gen #(
    parameter int CNT_W        = 12,
    parameter int FRAME_CNT_W  = 16,
    parameter int DEFAULT_MODE = 2
) (
    input  logic                   I_pxl_clk,
    input  logic                   I_rst_n,
    input  logic [1:0]             I_mode,
    input  logic [CNT_W-1:0]       I_h_total,
    input  logic [CNT_W-1:0]       I_h_sync,
    input  logic [CNT_W-1:0]       I_h_bporch,
    input  logic [CNT_W-1:0]       I_h_res,
    input  logic [CNT_W-1:0]       I_v_total,
    input  logic [CNT_W-1:0]       I_v_sync,
    input  logic [CNT_W-1:0]       I_v_bporch,
    input  logic [CNT_W-1:0]       I_v_res,
    input  logic                   I_hs_pol,
    input  logic                   I_vs_pol,
    output logic                   O_de,
    output logic                   O_hs,
    output logic                   O_vs,
    output logic [CNT_W-1:0]       O_x,
    output logic [CNT_W-1:0]       O_y,
    output logic                   O_line_start,
    output logic                   O_frame_start,
    output logic [FRAME_CNT_W-1:0] O_frame_cnt,
    output logic [1:0]             O_cur_mode,
    output logic                   O_cfg_err,
    output logic [7:0]             O_data_r,
    output logic [7:0]             O_data_g,
    output logic [7:0]             O_data_b
);
    localparam int SW = CNT_W + 2;

    typedef struct packed {
        logic [CNT_W-1:0] h_total, h_sync, h_bporch, h_res;
        logic [CNT_W-1:0] v_total, v_sync, v_bporch, v_res;
        logic             hs_pol, vs_pol;
    } cfg_t;

    function automatic cfg_t mk(input int ht, hs, hb, hr, vt, vs, vb, vr);
        return '{CNT_W'(ht), CNT_W'(hs), CNT_W'(hb), CNT_W'(hr),
                 CNT_W'(vt), CNT_W'(vs), CNT_W'(vb), CNT_W'(vr), 1'b1, 1'b1};
    endfunction

    // Mode 3 has no preset; it falls back to the 1280x720 timing if ever used at reset.
    function automatic cfg_t preset(input logic [1:0] m);
        return m == 2'd0 ? mk(1056, 128, 88, 800, 628, 4, 23, 600)
             : m == 2'd1 ? mk(1344, 136, 160, 1024, 806, 6, 29, 768)
             :             mk(1650, 40, 220, 1280, 750, 5, 20, 720);
    endfunction

    localparam cfg_t RST_CFG = preset(2'(DEFAULT_MODE));

    cfg_t             cfg, req;
    logic [CNT_W-1:0] h_cnt, v_cnt, px, py;
    logic [SW-1:0]    h_need, v_need, h_start, v_start;
    logic             h_end, v_end, boundary, req_ok, h_act, v_act, de;

    assign req = I_mode == 2'd3
               ? {I_h_total, I_h_sync, I_h_bporch, I_h_res,
                  I_v_total, I_v_sync, I_v_bporch, I_v_res, I_hs_pol, I_vs_pol}
               : preset(I_mode);
    assign h_need = SW'(I_h_sync) + SW'(I_h_bporch) + SW'(I_h_res) + SW'(1);
    assign v_need = SW'(I_v_sync) + SW'(I_v_bporch) + SW'(I_v_res) + SW'(1);
    assign req_ok = I_mode != 2'd3 ||
                    (SW'(I_h_total) >= h_need && SW'(I_v_total) >= v_need &&
                     I_h_sync != '0 && I_h_res != '0 && I_v_sync != '0 && I_v_res != '0);

    assign h_end    = h_cnt == cfg.h_total - 1'b1;
    assign v_end    = v_cnt == cfg.v_total - 1'b1;
    assign boundary = h_end && v_end;

    always_ff @(posedge I_pxl_clk or negedge I_rst_n)
        if (!I_rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            cfg         <= RST_CFG;
            O_cur_mode  <= 2'(DEFAULT_MODE);
            O_cfg_err   <= 1'b0;
            O_frame_cnt <= '0;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            v_cnt <= !h_end ? v_cnt : v_end ? '0 : v_cnt + 1'b1;
            if (boundary) begin
                O_frame_cnt <= O_frame_cnt + 1'b1;
                O_cfg_err   <= !req_ok;
                if (req_ok) begin
                    cfg        <= req;
                    O_cur_mode <= I_mode;
                end
            end
        end

    assign h_start = SW'(cfg.h_sync) + SW'(cfg.h_bporch);
    assign v_start = SW'(cfg.v_sync) + SW'(cfg.v_bporch);
    assign h_act   = SW'(h_cnt) >= h_start && SW'(h_cnt) < h_start + SW'(cfg.h_res);
    assign v_act   = SW'(v_cnt) >= v_start && SW'(v_cnt) < v_start + SW'(cfg.v_res);
    assign de      = h_act && v_act;
    assign px      = CNT_W'(SW'(h_cnt) - h_start);
    assign py      = CNT_W'(SW'(v_cnt) - v_start);

    always_ff @(posedge I_pxl_clk or negedge I_rst_n)
        if (!I_rst_n) begin
            O_de          <= 1'b0;
            O_hs          <= !RST_CFG.hs_pol;
            O_vs          <= !RST_CFG.vs_pol;
            O_x           <= '0;
            O_y           <= '0;
            O_line_start  <= 1'b0;
            O_frame_start <= 1'b0;
        end else begin
            O_de          <= de;
            O_hs          <= (h_cnt < cfg.h_sync) ~^ cfg.hs_pol;
            O_vs          <= (v_cnt < cfg.v_sync) ~^ cfg.vs_pol;
            O_x           <= de ? px : '0;
            O_y           <= de ? py : '0;
            O_line_start  <= h_cnt == '0;
            O_frame_start <= h_cnt == '0 && v_cnt == '0;
        end

`ifdef VIDEO_TIMING_GEN_TPG_EN
    logic [CNT_W-1:0] bar_w;
    logic [2:0]       bar;

    assign bar_w = cfg.h_res >> 3;

    // Bar index = count of bar edges already passed; saturates at 7 so the remainder joins the last bar.
    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++)
            bar = bar + {2'b0, SW'(px) >= SW'(k) * SW'(bar_w)};
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n)
        if (!I_rst_n) begin
            O_data_r <= '0;
            O_data_g <= '0;
            O_data_b <= '0;
        end else begin
            O_data_r <= {8{de && !bar[1]}};
            O_data_g <= {8{de && !bar[2]}};
            O_data_b <= {8{de && !bar[0]}};
        end
`else
    assign O_data_r = '0;
    assign O_data_g = '0;
    assign O_data_b = '0;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized checks of video_timing_gen against a cycle-level reference model.
module tb_video_timing_gen;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  mode;
    logic [11:0] h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res;
    logic        hs_pol, vs_pol;
    logic        de, hs, vs, ls, fs, err;
    logic [11:0] x, y;
    logic [15:0] fcnt;
    logic [1:0]  cur_mode;
    logic [7:0]  r, g, b;

    video_timing_gen dut (
        .I_pxl_clk(clk), .I_rst_n(rst_n), .I_mode(mode),
        .I_h_total(h_total), .I_h_sync(h_sync), .I_h_bporch(h_bporch), .I_h_res(h_res),
        .I_v_total(v_total), .I_v_sync(v_sync), .I_v_bporch(v_bporch), .I_v_res(v_res),
        .I_hs_pol(hs_pol), .I_vs_pol(vs_pol),
        .O_de(de), .O_hs(hs), .O_vs(vs), .O_x(x), .O_y(y),
        .O_line_start(ls), .O_frame_start(fs), .O_frame_cnt(fcnt),
        .O_cur_mode(cur_mode), .O_cfg_err(err),
        .O_data_r(r), .O_data_g(g), .O_data_b(b)
    );

    typedef struct packed {
        logic        de, hs, vs, ls, fs, err;
        logic [1:0]  cur_mode;
        logic [11:0] x, y;
        logic [15:0] fcnt;
        logic [7:0]  r, g, b;
    } obs_t;

    typedef struct {
        int ht, hs, hb, hr, vt, vs, vb, vr;
        bit hp, vp;
    } mcfg_t;

    obs_t        obs;
    mcfg_t       m_cfg;
    int          m_h, m_v, m_mode;
    bit          m_err;
    logic [15:0] m_fcnt;
    int          compared = 0, mismatched = 0;

    assign obs = '{de, hs, vs, ls, fs, err, cur_mode, x, y, fcnt, r, g, b};

`ifdef VIDEO_TIMING_GEN_TPG_EN
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

    function automatic mcfg_t preset_of(int md);
        if (md == 0) return '{1056, 128, 88, 800, 628, 4, 23, 600, 1'b1, 1'b1};
        if (md == 1) return '{1344, 136, 160, 1024, 806, 6, 29, 768, 1'b1, 1'b1};
        return '{1650, 40, 220, 1280, 750, 5, 20, 720, 1'b1, 1'b1};
    endfunction

    function automatic mcfg_t custom_req();
        return '{int'(h_total), int'(h_sync), int'(h_bporch), int'(h_res),
                 int'(v_total), int'(v_sync), int'(v_bporch), int'(v_res), hs_pol, vs_pol};
    endfunction

    function automatic bit custom_ok();
        mcfg_t c = custom_req();
        return c.ht >= c.hs + c.hb + c.hr + 1 && c.vt >= c.vs + c.vb + c.vr + 1 &&
               c.hs != 0 && c.hr != 0 && c.vs != 0 && c.vr != 0;
    endfunction

    task automatic model_init();
        m_cfg = preset_of(2); m_h = 0; m_v = 0; m_mode = 2; m_err = 1'b0; m_fcnt = '0;
    endtask

    task automatic set_custom(input int ht, hs_, hb, hr, vt, vs_, vb, vr, input bit hp, vp);
        h_total = 12'(ht); h_sync = 12'(hs_); h_bporch = 12'(hb); h_res = 12'(hr);
        v_total = 12'(vt); v_sync = 12'(vs_); v_bporch = 12'(vb); v_res = 12'(vr);
        hs_pol = hp; vs_pol = vp;
    endtask

    task automatic rand_inputs();
        mode = 2'($urandom);
        set_custom($urandom_range(0, 4095), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 2047), $urandom_range(0, 4095), $urandom_range(0, 63),
                   $urandom_range(0, 63), $urandom_range(0, 2047), 1'($urandom), 1'($urandom));
    endtask

    // Expected outputs for the coming edge, then the model advances one pixel and the clock ticks.
    task automatic tick(output obs_t e);
        int hst, vst, px, py;
        bit act;
        hst = m_cfg.hs + m_cfg.hb;
        vst = m_cfg.vs + m_cfg.vb;
        act = m_h >= hst && m_h < hst + m_cfg.hr && m_v >= vst && m_v < vst + m_cfg.vr;
        px  = act ? m_h - hst : 0;
        py  = act ? m_v - vst : 0;
        e = '0;
        e.de = act;
        e.hs = (m_h < m_cfg.hs) == m_cfg.hp;
        e.vs = (m_v < m_cfg.vs) == m_cfg.vp;
        e.ls = m_h == 0;
        e.fs = m_h == 0 && m_v == 0;
        e.x  = 12'(px);
        e.y  = 12'(py);
`ifdef VIDEO_TIMING_GEN_TPG_EN
        if (act) begin
            int bar;
            bar = m_cfg.hr / 8 == 0 ? 7 : px / (m_cfg.hr / 8);
            if (bar > 7) bar = 7;
            {e.r, e.g, e.b} = bars[bar];
        end
`endif
        if (m_h == m_cfg.ht - 1 && m_v == m_cfg.vt - 1) begin
            m_fcnt++;
            if (mode != 2'd3 || custom_ok()) begin
                m_cfg  = mode == 2'd3 ? custom_req() : preset_of(int'(mode));
                m_mode = int'(mode);
                m_err  = 1'b0;
            end else
                m_err = 1'b1;
            m_h = 0;
            m_v = 0;
        end else if (m_h == m_cfg.ht - 1) begin
            m_h = 0;
            m_v++;
        end else
            m_h++;
        e.fcnt     = m_fcnt;
        e.err      = m_err;
        e.cur_mode = 2'(m_mode);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, rst_e;
        rst_e = '0;
        rst_e.cur_mode = 2'd2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (obs !== rst_e) begin
            mismatched++;
            $display("FAIL reset_state: got %h expected %h", obs, rst_e);
        end
        rst_n = 1'b1;
        model_init();
        for (int c = 0; c < 5; c++) begin
            tick(e);
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL reset_release cyc %0d: got %h expected %h", c, obs, e);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (obs !== rst_e) begin
            mismatched++;
            $display("FAIL async_reset: got %h expected %h", obs, rst_e);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_init();
    endtask

    task automatic test_mode2_frame();
        obs_t e;
        int c, ls_n, de_lines, hs_n, de_first, de_len, x_last;
        bit prev_de;
        logic [23:0] exp_rgb;
        ls_n = 0; de_lines = 0; hs_n = 0; de_first = -1; de_len = 0; x_last = -1; prev_de = 0;
        for (c = 0; c < 1650 * 750 + 1; c++) begin
            if (m_v == 749 && m_h == 0) begin
                set_custom(20, 2, 2, 8, 12, 1, 1, 6, 1'b0, 1'b1);
                mode = 2'd3;
            end else if (m_v < 749 && $urandom_range(0, 499) == 0)
                rand_inputs();
            tick(e);
            if (c < 27 * 1650) begin
                compared++;
                if (obs !== e) begin
                    mismatched++;
                    $display("FAIL mode2_pixel cyc %0d: got %h expected %h", c, obs, e);
                end
            end
            if (c == 0) begin
                compared++;
                if (obs.fs !== 1'b1) begin
                    mismatched++;
                    $display("FAIL first_frame_start: got %b expected 1", obs.fs);
                end
            end
            if (c > 0 && obs.fs) break;
            ls_n += int'(obs.ls);
            if (obs.de && !prev_de) de_lines++;
            prev_de = obs.de;
            if (c < 1650) hs_n += int'(obs.hs);
            if (c >= 25 * 1650 && c < 26 * 1650) begin
                if (obs.de && de_first < 0) de_first = c - 25 * 1650;
                de_len += int'(obs.de);
                if (obs.de) x_last = int'(obs.x);
                if (c == 25 * 1650 || (obs.de && (obs.x == 0 || obs.x == 160 || obs.x == 1120))) begin
`ifdef VIDEO_TIMING_GEN_TPG_EN
                    exp_rgb = !obs.de ? 24'h0 : obs.x == 0 ? 24'hFFFFFF : obs.x == 160 ? 24'hFFFF00 : 24'h000000;
`else
                    exp_rgb = 24'h0;
`endif
                    compared++;
                    if ({obs.r, obs.g, obs.b} !== exp_rgb) begin
                        mismatched++;
                        $display("FAIL tpg_rgb x=%0d de=%b: got %h expected %h", obs.x, obs.de, {obs.r, obs.g, obs.b}, exp_rgb);
                    end
                end
            end
        end
        compared += 8;
        if (c != 1650 * 750) begin mismatched++; $display("FAIL frame_length: got %0d expected 1237500", c); end
        if (ls_n != 750) begin mismatched++; $display("FAIL lines_per_frame: got %0d expected 750", ls_n); end
        if (de_lines != 720) begin mismatched++; $display("FAIL active_lines: got %0d expected 720", de_lines); end
        if (hs_n != 40) begin mismatched++; $display("FAIL hs_width: got %0d expected 40", hs_n); end
        if (de_first != 260) begin mismatched++; $display("FAIL de_offset: got %0d expected 260", de_first); end
        if (de_len != 1280) begin mismatched++; $display("FAIL de_width: got %0d expected 1280", de_len); end
        if (x_last != 1279) begin mismatched++; $display("FAIL x_last: got %0d expected 1279", x_last); end
        if (obs !== e || obs.cur_mode !== 2'd3 || obs.fcnt !== 16'd1) begin
            mismatched++;
            $display("FAIL switch_to_custom: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_custom();
        obs_t e;
        int hs_low, de_n, ls_n, fs_n;
        logic [15:0] f0;
        hs_low = 0; de_n = 0; ls_n = 0; fs_n = 0;
        f0 = obs.fcnt;
        for (int c = 0; c < 720; c++) begin
            tick(e);
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL custom_pixel cyc %0d: got %h expected %h", c, obs, e);
            end
            hs_low += int'(!obs.hs);
            de_n   += int'(obs.de);
            ls_n   += int'(obs.ls);
            fs_n   += int'(obs.fs);
        end
        compared += 5;
        if (hs_low != 72) begin mismatched++; $display("FAIL custom_hs_low: got %0d expected 72", hs_low); end
        if (de_n != 144) begin mismatched++; $display("FAIL custom_de: got %0d expected 144", de_n); end
        if (ls_n != 36) begin mismatched++; $display("FAIL custom_lines: got %0d expected 36", ls_n); end
        if (fs_n != 3) begin mismatched++; $display("FAIL custom_frames: got %0d expected 3", fs_n); end
        if (obs.fcnt !== f0 + 16'd3) begin mismatched++; $display("FAIL custom_fcnt: got %0d expected %0d", obs.fcnt, f0 + 16'd3); end
    endtask

    task automatic test_cfg_err();
        obs_t e;
        int ls_n, fs_n;
        ls_n = 0; fs_n = 0;
        set_custom(100, 10, 10, 90, 12, 1, 1, 6, 1'b1, 1'b1);
        mode = 2'd3;
        for (int c = 0; c < 720; c++) begin
            tick(e);
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL cfg_err_pixel cyc %0d: got %h expected %h", c, obs, e);
            end
            ls_n += int'(obs.ls);
            fs_n += int'(obs.fs);
        end
        compared += 3;
        if (obs.err !== 1'b1) begin mismatched++; $display("FAIL cfg_err_set: got %b expected 1", obs.err); end
        if (ls_n != 36 || fs_n != 3) begin mismatched++; $display("FAIL cfg_err_timing: got %0d/%0d expected 36/3", ls_n, fs_n); end
        if (obs.cur_mode !== 2'd3) begin mismatched++; $display("FAIL cfg_err_mode: got %0d expected 3", obs.cur_mode); end
    endtask

    task automatic test_random_custom();
        obs_t e;
        logic [15:0] f0;
        int n;
        for (int it = 0; it < 12; it++) begin
            set_custom($urandom_range(3, 24), $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 12),
                       $urandom_range(3, 24), $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 12),
                       1'($urandom), 1'($urandom));
            mode = 2'd3;
            f0 = m_fcnt;
            for (n = 0; n < 1400 && m_fcnt != f0 + 16'd2; n++) begin
                tick(e);
                compared++;
                if (obs !== e) begin
                    mismatched++;
                    $display("FAIL random_custom it %0d cyc %0d: got %h expected %h", it, n, obs, e);
                end
            end
            compared++;
            if (m_fcnt != f0 + 16'd2) begin
                mismatched++;
                $display("FAIL random_custom_timeout it %0d: got %0d frames expected 2", it, m_fcnt - f0);
            end
        end
    endtask

    task automatic test_mode1_switch();
        obs_t e;
        logic [15:0] f0;
        int second, hs_n, n;
        set_custom(20, 0, 2, 8, 12, 1, 1, 6, 1'b1, 1'b1);
        mode = 2'd3;
        f0 = m_fcnt;
        for (n = 0; n < 1200 && m_fcnt == f0; n++) begin
            tick(e);
            compared++;
            if (obs !== e) begin mismatched++; $display("FAIL reject_pixel cyc %0d: got %h expected %h", n, obs, e); end
        end
        compared++;
        if (obs.err !== 1'b1) begin mismatched++; $display("FAIL reject_err: got %b expected 1", obs.err); end
        f0 = m_fcnt;
        for (n = 0; n < 1200 && m_fcnt == f0; n++) begin
            mode = (m_h == m_cfg.ht - 1 && m_v == m_cfg.vt - 1) ? 2'd1 : 2'($urandom);
            tick(e);
            compared++;
            if (obs !== e) begin mismatched++; $display("FAIL pre_switch_pixel cyc %0d: got %h expected %h", n, obs, e); end
        end
        mode = 2'd1;
        second = -1; hs_n = 0;
        for (int c = 0; c < 2 * 1344; c++) begin
            tick(e);
            compared++;
            if (obs !== e) begin mismatched++; $display("FAIL mode1_pixel cyc %0d: got %h expected %h", c, obs, e); end
            if (c == 0) begin
                compared++;
                if (obs.fs !== 1'b1 || obs.cur_mode !== 2'd1 || obs.err !== 1'b0) begin
                    mismatched++;
                    $display("FAIL mode1_start: got fs=%b mode=%0d err=%b expected fs=1 mode=1 err=0", obs.fs, obs.cur_mode, obs.err);
                end
            end
            if (c > 0 && obs.ls && second < 0) second = c;
            if (c < 1344) hs_n += int'(obs.hs);
        end
        compared += 2;
        if (second != 1344) begin mismatched++; $display("FAIL mode1_line_len: got %0d expected 1344", second); end
        if (hs_n != 136) begin mismatched++; $display("FAIL mode1_hs_width: got %0d expected 136", hs_n); end
    endtask

    initial begin
        mode = 2'd2;
        set_custom(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
        model_init();
        test_reset();
        test_mode2_frame();
        test_custom();
        test_cfg_err();
        test_random_custom();
        test_mode1_switch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
